explore_serial_harness: RTL and testbench
=========================================

Name: explore_serial_harness

Overview:
- Next-generation size-exploration harness: operands shift in serially on three 1-bit channels, run through a mode-selectable arithmetic unit, and the result reads back a byte at a time.
- Generalised in operand width, accumulator width and operation mode. Adds start/busy/done handshake, iterative shift-add multiplier, persistent FMA accumulator with sticky overflow.
- Sits directly behind top-level pin muxing: ui_in bits drive serial/control inputs; uo_out carries rd_byte.

Parameters:
WIDTH, 8, operand width in bits (2..16)
ACC_W, 32, result/accumulator width in bits; multiple of 8, >= 2*WIDTH+1

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
ena  input  1  global enable; 0 freezes all state (FSM, shift regs, acc)
ser_in  input  3  serial operand bits: [0]=a, [1]=b, [2]=c, MSB first
shift_en  input  1  shift ser_in into operand regs this cycle
mode  input  2  0=ADD, 1=MULT, 2=FMA, 3=MAC
start  input  1  launch operation (sampled in IDLE only)
clear_acc  input  1  clear accumulator and overflow (IDLE only)
byte_sel  input  clog2(ACC_W/8) (min 1)  result byte index
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
overflow  output  1  sticky FMA accumulator carry-out
rd_byte  output  8  result[8*byte_sel +: 8]

Behaviour:
- Reset (async, rst_n=0): operand regs a/b/c, result, acc, overflow, busy, done all 0; FSM=IDLE. Reset mid-EXEC aborts the op; no result update.
- All sequential activity gated by ena=1; with ena=0 every register holds. done stays high until ena returns.
- Operand load: in IDLE with shift_en=1, each reg x <= {x[WIDTH-2:0], ser_in[i]}. Ignored while busy/done.
- FSM IDLE -> EXEC -> DONE -> IDLE.
- IDLE: start=1 at edge t0: latch mode, snapshot a/b/c into working regs, cycle counter=N-1, busy=1. N=1 for ADD, N=WIDTH for MULT/FMA/MAC.
- Simultaneous start and clear_acc: clear applies first, then op starts (FMA sees acc=0).
- Simultaneous start and shift_en: shift is not taken; op uses pre-edge operands.
- EXEC: one multiplier bit per cycle, LSB first; partial product += b<<k when a[k]=1. Counter decrements.
- At edge t0+N: result register written, FSM=DONE, busy=0, done=1.
- At edge t0+N+1: FSM=IDLE, done=0.
- start during EXEC/DONE ignored (no queueing).
- Arithmetic, all unsigned, zero-extended to ACC_W:
  - ADD: a+b (WIDTH+1 bits).
  - MULT: a*b (2*WIDTH bits).
  - MAC: a*b+c.
  - FMA: acc <= (acc + a*b) mod 2^ACC_W; result <= new acc. Carry-out sets overflow (sticky). Non-FMA modes leave acc/overflow unchanged.
- clear_acc in IDLE: acc=0, overflow=0 next edge; result unchanged. Ignored when not IDLE.
- rd_byte combinational from result register; byte_sel >= ACC_W/8 gives 0x00. Result holds until next completed op.

Test Plan:
- WIDTH=8, ACC_W=32. Shift a=0xC8, b=0x64 (8 shift cycles), mode=ADD, start -> busy 1 cycle; done 1 cycle after start edge; result 0x0000012C; byte_sel 0..3 = 2C,01,00,00.
- Shift a=b=0xFF, MULT, start -> busy 8 cycles, done exactly 8 edges after start edge, result 0xFE01. Start pulses during busy produce no second done.
- FMA a=200, b=100, three starts -> results 20000, 40000, 60000 (0xEA60); clear_acc in IDLE -> next FMA gives 20000; overflow=0 throughout.
- ACC_W=16 instance: FMA 0xFF*0xFF twice -> 0xFE01 then 0xFC02, overflow=1 after second done, stays 1 through a MULT op, cleared only by clear_acc.
- MAC a=3, b=5, c=7 -> 22 (0x16). shift_en during EXEC leaves operands unchanged (re-start gives 22 again). ena=0 for 4 cycles mid-EXEC stretches latency by exactly 4.
- rst_n low mid-EXEC of MULT -> busy/done/result/acc immediately 0. After release, IDLE; new ADD 1+1 returns 2.

Source files
------------

// File: rtl/explore_serial_harness.sv
// ============================================================================
// explore_serial_harness
//   Serially loaded operands feed an ADD / MULT / FMA / MAC unit with an
//   iterative shift-add multiplier; the result reads back one byte at a time.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module explore_serial_harness #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 32,
   localparam int NBYTES = ACC_W / 8,
   localparam int BSW = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic [2:0]     ser_in,
   input  logic           shift_en,
   input  logic [1:0]     mode,
   input  logic           start,
   input  logic           clear_acc,
   input  logic [BSW-1:0] byte_sel,
   output logic           busy,
   output logic           done,
   output logic           overflow,
   output logic [7:0]     rd_byte
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_MULT = 2'd1;
   localparam logic [1:0] OP_MAC  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, c_q, c_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   ma_q, ma_d, mc_q, mc_d;
   logic [ACC_W-1:0]   mb_q, mb_d, prod_q, prod_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ACC_W-1:0]   result_q, result_d, acc_q, acc_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   pp;
   logic [ACC_W:0]     fma_sum;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      op_d     = op_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      mc_d     = mc_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      acc_d    = acc_q;
      ovf_d    = ovf_q;

      pp      = prod_q + (ma_q[0] ? mb_q : '0);
      fma_sum = {1'b0, acc_q} + {1'b0, pp};

      case (state_q)
         S_IDLE: begin
            // clear is applied before a same-cycle FMA reads the accumulator
            if (clear_acc) begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
            if (start) begin
               state_d = S_EXEC;
               op_d    = mode;
               ma_d    = a_q;
               mb_d    = ACC_W'(b_q);
               mc_d    = c_q;
               prod_d  = '0;
               cnt_d   = (mode == OP_ADD) ? '0 : CW'(WIDTH - 1);
            end else if (shift_en) begin
               a_d = {a_q[WIDTH-2:0], ser_in[0]};
               b_d = {b_q[WIDTH-2:0], ser_in[1]};
               c_d = {c_q[WIDTH-2:0], ser_in[2]};
            end
         end
         S_EXEC: begin
            prod_d = pp;
            ma_d   = ma_q >> 1;
            mb_d   = mb_q << 1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               // ADD finishes on its first EXEC cycle, so ma/mb are still unshifted
               case (op_q)
                  OP_ADD:  result_d = ACC_W'(ma_q) + mb_q;
                  OP_MULT: result_d = pp;
                  OP_MAC:  result_d = pp + ACC_W'(mc_q);
                  default: begin
                     acc_d    = fma_sum[ACC_W-1:0];
                     result_d = fma_sum[ACC_W-1:0];
                     ovf_d    = ovf_q | fma_sum[ACC_W];
                  end
               endcase
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         op_q     <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         mc_q     <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         acc_q    <= '0;
         ovf_q    <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         op_q     <= op_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         mc_q     <= mc_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         acc_q    <= acc_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == S_EXEC);
   assign done     = (state_q == S_DONE);
   assign overflow = ovf_q;

   // out-of-range byte indices fall through to zero
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < NBYTES; i++) begin
         if (byte_sel == BSW'(i)) rd_byte = result_q[8*i +: 8];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_explore_serial_harness.sv
// ============================================================================
// tb_explore_serial_harness: table vectors, corner sequences and random ops
// checked against an arithmetic reference model; ACC_W=32 and ACC_W=16 DUTs.
// ============================================================================
`default_nettype none

module tb_explore_serial_harness;

   localparam int W = 8;
   localparam logic [1:0] OP_ADD  = 2'd0;
   localparam logic [1:0] OP_MULT = 2'd1;
   localparam logic [1:0] OP_FMA  = 2'd2;
   localparam logic [1:0] OP_MAC  = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n, ena, shift_en, start, clear_acc;
   logic [2:0] ser_in;
   logic [1:0] mode, byte_sel;
   logic       busy32, done32, ovf32, busy16, done16, ovf16;
   logic [7:0] rd32, rd16;

   int compared   = 0;
   int mismatched = 0;

   // reference model state
   logic [W-1:0] ma, mb, mc;
   logic [31:0]  acc32, res32;
   logic [15:0]  acc16, res16;
   logic         mov32, mov16;

   always #5 clk = ~clk;

   explore_serial_harness #(.WIDTH(W), .ACC_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ser_in(ser_in), .shift_en(shift_en),
      .mode(mode), .start(start), .clear_acc(clear_acc), .byte_sel(byte_sel),
      .busy(busy32), .done(done32), .overflow(ovf32), .rd_byte(rd32));

   explore_serial_harness #(.WIDTH(W), .ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ser_in(ser_in), .shift_en(shift_en),
      .mode(mode), .start(start), .clear_acc(clear_acc), .byte_sel(byte_sel[0]),
      .busy(busy16), .done(done16), .overflow(ovf16), .rd_byte(rd16));

   typedef struct {
      logic [1:0]  m;
      bit          load;
      logic [7:0]  a, b, c;
      logic [31:0] exp;
      bit          pstart, pshift;
      int          stall;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_bytes(input string tag, input logic [31:0] e32, input logic [15:0] e16);
      for (int k = 0; k < 4; k++) begin
         byte_sel = 2'(k);
         #1;
         check($sformatf("%s rd32[%0d]", tag, k), 64'(rd32), 64'(e32[8*k +: 8]));
         if (k < 2) check($sformatf("%s rd16[%0d]", tag, k), 64'(rd16), 64'(e16[8*k +: 8]));
      end
   endtask

   task automatic model_reset();
      ma = '0; mb = '0; mc = '0;
      acc32 = '0; acc16 = '0; res32 = '0; res16 = '0;
      mov32 = 1'b0; mov16 = 1'b0;
   endtask

   task automatic shift_in(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      for (int i = W - 1; i >= 0; i--) begin
         ser_in   = {c[i], b[i], a[i]};
         shift_en = 1'b1;
         tick();
         ma = {ma[W-2:0], a[i]};
         mb = {mb[W-2:0], b[i]};
         mc = {mc[W-2:0], c[i]};
      end
      shift_en = 1'b0;
   endtask

   task automatic clear_task();
      clear_acc = 1'b1;
      tick();
      clear_acc = 1'b0;
      acc32 = '0; acc16 = '0; mov32 = 1'b0; mov16 = 1'b0;
      check("clear ovf32", 64'(ovf32), 64'(mov32));
      check("clear ovf16", 64'(ovf16), 64'(mov16));
      check_bytes("clear hold", res32, res16);
   endtask

   task automatic do_op(input logic [1:0] m, input bit clr, input bit sshift, input bit pstart,
                        input bit pshift, input int stall, input bit ovr, input logic [31:0] oval,
                        input string tag);
      logic [63:0] p, v, s;
      logic [31:0] e32;
      logic [15:0] e16;
      int n, edges, bcnt;
      if (clr) begin
         acc32 = '0; acc16 = '0; mov32 = 1'b0; mov16 = 1'b0;
      end
      p = 64'(ma) * 64'(mb);
      v = '0;
      case (m)
         OP_ADD:  v = 64'(ma) + 64'(mb);
         OP_MULT: v = p;
         OP_MAC:  v = p + 64'(mc);
         default: ;
      endcase
      if (m == OP_FMA) begin
         s = 64'(acc32) + p;
         mov32 = mov32 | s[32];
         acc32 = s[31:0];
         res32 = acc32;
         s = 64'(acc16) + p;
         mov16 = mov16 | s[16];
         acc16 = s[15:0];
         res16 = acc16;
      end else begin
         res32 = v[31:0];
         res16 = v[15:0];
      end
      e32 = ovr ? oval : res32;
      e16 = ovr ? oval[15:0] : res16;
      n = (m == OP_ADD) ? 1 : W;

      mode = m; start = 1'b1; clear_acc = clr; shift_en = sshift; ser_in = 3'($urandom);
      tick();
      start = 1'b0; clear_acc = 1'b0; shift_en = 1'b0;
      edges = 0; bcnt = 0;
      while (!done32 && edges < 100) begin
         if (busy32) bcnt++;
         if (stall > 0 && edges == 3) ena = 1'b0;
         if (stall > 0 && edges == 3 + stall) ena = 1'b1;
         start = pstart; shift_en = pshift; ser_in = 3'($urandom); mode = 2'($urandom);
         tick();
         edges++;
      end
      ena = 1'b1;
      check({tag, " latency"}, 64'(edges), 64'(n + stall));
      check({tag, " busy cycles"}, 64'(bcnt), 64'(n + stall));
      check({tag, " done16"}, 64'(done16), 64'd1);
      check({tag, " busy at done"}, 64'(busy32), 64'd0);
      check_bytes(tag, e32, e16);
      check({tag, " ovf32"}, 64'(ovf32), 64'(mov32));
      check({tag, " ovf16"}, 64'(ovf16), 64'(mov16));
      tick();
      start = 1'b0; shift_en = 1'b0;
      check({tag, " done pulse"}, 64'(done32), 64'd0);
      tick();
      check({tag, " no requeue busy"}, 64'(busy32), 64'd0);
      check({tag, " no requeue done"}, 64'(done32), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{OP_ADD,  1'b1, 8'hC8, 8'h64, 8'h00, 32'h0000012C, 1'b0, 1'b0, 0};
      vecs[1] = '{OP_MULT, 1'b1, 8'hFF, 8'hFF, 8'h00, 32'h0000FE01, 1'b1, 1'b0, 0};
      vecs[2] = '{OP_MAC,  1'b1, 8'h03, 8'h05, 8'h07, 32'h00000016, 1'b0, 1'b1, 0};
      vecs[3] = '{OP_MAC,  1'b0, 8'h00, 8'h00, 8'h00, 32'h00000016, 1'b0, 1'b0, 4};
      vecs[4] = '{OP_ADD,  1'b1, 8'hFF, 8'hFF, 8'h5A, 32'h000001FE, 1'b0, 1'b0, 0};
      vecs[5] = '{OP_MULT, 1'b1, 8'h00, 8'hAB, 8'hCD, 32'h00000000, 1'b0, 1'b0, 0};
      vecs[6] = '{OP_MAC,  1'b1, 8'hFF, 8'hFF, 8'hFF, 32'h0000FF00, 1'b0, 1'b0, 0};

      rst_n = 1'b0; ena = 1'b1; shift_en = 1'b0; start = 1'b0; clear_acc = 1'b0;
      ser_in = '0; mode = '0; byte_sel = '0;
      model_reset();
      repeat (3) tick();
      check("reset busy", 64'(busy32), 64'd0);
      check("reset done", 64'(done32), 64'd0);
      check("reset ovf", 64'(ovf32), 64'd0);
      check_bytes("reset", 32'd0, 16'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].load) shift_in(vecs[i].a, vecs[i].b, vecs[i].c);
         do_op(vecs[i].m, 1'b0, 1'b0, vecs[i].pstart, vecs[i].pshift, vecs[i].stall,
               1'b1, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // FMA accumulation, clear in IDLE, and clear coincident with start
      clear_task();
      shift_in(8'd200, 8'd100, 8'd0);
      do_op(OP_FMA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd20000, "fma1");
      do_op(OP_FMA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd40000, "fma2");
      do_op(OP_FMA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd60000, "fma3");
      clear_task();
      do_op(OP_FMA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd20000, "fma after clear");
      do_op(OP_FMA, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'd20000, "fma clear+start");

      // 16-bit accumulator wraps; sticky overflow survives a MULT
      clear_task();
      shift_in(8'hFF, 8'hFF, 8'h00);
      do_op(OP_FMA,  1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0000FE01, "fma16 a");
      do_op(OP_FMA,  1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'h0001FC02, "fma16 b");
      do_op(OP_MULT, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 32'h0000FE01, "mult keeps ovf");
      clear_task();

      for (int it = 0; it < 40; it++) begin
         logic [1:0] m;
         if ($urandom_range(2) != 0)
            shift_in(8'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(7) == 0) clear_task();
         m = 2'($urandom);
         do_op(m, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               (m == OP_ADD) ? 0 : int'($urandom_range(3)), 1'b0, 32'd0,
               $sformatf("rand%0d", it));
      end

      // asynchronous reset in the middle of a MULT
      shift_in(8'hFF, 8'hFF, 8'h00);
      mode = OP_MULT; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midreset busy", 64'(busy32), 64'd0);
      check("midreset done", 64'(done32), 64'd0);
      check("midreset ovf16", 64'(ovf16), 64'd0);
      check_bytes("midreset", 32'd0, 16'd0);
      #2 rst_n = 1'b1;
      tick();
      check("post reset idle busy", 64'(busy32), 64'd0);
      shift_in(8'd1, 8'd1, 8'd0);
      do_op(OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd2, "add after reset");
      shift_in(8'd2, 8'd3, 8'd0);
      do_op(OP_FMA, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'd6, "fma acc reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
